load_store_unit: RTL and testbench

//  Data-memory access stage driven by the main controller's MemRead/MemWrite strobes.

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: RISC-V funct3 access
// encodings and the LSU sequencing states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsuState_t;

  // Stores have no unsigned variants, so BU/HU are only legal on loads.
  function automatic logic isStoreSizeLegal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and the memory (slave).
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane steering: store lane replication/enables with misalign
// detection, and load byte/half selection with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,

  input  logic [31:0] rdata,
  input  logic [2:0]  loadFunct3,
  input  logic [1:0]  loadOffset,
  output logic [31:0] loadData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // misalign also flags encodings that are not a valid access size at all.
  always_comb begin
    be       = 4'b0000;
    wdata    = storeData;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << offset;
        wdata = {4{storeData[7:0]}};
      end
      F3_H, F3_HU: begin
        be       = offset[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{storeData[15:0]}};
        misalign = offset[0];
      end
      F3_W: begin
        be       = 4'b1111;
        wdata    = storeData;
        misalign = (offset != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    byteSel = rdata[7:0];
    case (loadOffset)
      2'd0: byteSel = rdata[7:0];
      2'd1: byteSel = rdata[15:8];
      2'd2: byteSel = rdata[23:16];
      2'd3: byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
  end

  assign halfSel = loadOffset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadData = rdata;
    case (loadFunct3)
      F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
      F3_BU:   loadData = {24'd0, byteSel};
      F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
      F3_HU:   loadData = {16'd0, halfSel};
      default: loadData = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one req/ack transaction per load or store, stalling
// the core until the access retires with a result, a fault or a bus error.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      stall,
  output logic [31:0]               load_data,
  output logic                      fault,
  output logic                      bus_err
);

  lsuState_t   state;
  logic [7:0]  counter;
  logic [2:0]  funct3Q;
  logic [1:0]  offsetQ;
  logic        op;
  logic        badAccess;
  logic [3:0]  storeBe;
  logic [31:0] storeWdata;
  logic        misalign;
  logic [31:0] extLoad;

  lsu_align u_align (
    .funct3     (funct3),
    .offset     (addr[1:0]),
    .storeData  (store_data),
    .be         (storeBe),
    .wdata      (storeWdata),
    .misalign   (misalign),
    .rdata      (mem.mem_rdata),
    .loadFunct3 (funct3Q),
    .loadOffset (offsetQ),
    .loadData   (extLoad)
  );

  assign op        = mem_read | mem_write;
  assign badAccess = misalign
                   | (mem_read & mem_write)
                   | (mem_write & ~isStoreSizeLegal(funct3));

  // Request follows the BUSY state so a reset drops it with the state register.
  assign mem.mem_req = (state == BUSY);
  assign stall       = ((state == IDLE) && op) || (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= 8'd0;
      funct3Q       <= 3'd0;
      offsetQ       <= 2'd0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_be    <= 4'd0;
      mem.mem_wdata <= 32'd0;
      load_data     <= 32'd0;
      fault         <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      fault   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          counter <= 8'd0;
          if (op) begin
            mem.mem_addr  <= {addr[31:2], 2'b00};
            mem.mem_we    <= mem_write;
            mem.mem_be    <= mem_write ? storeBe : 4'b1111;
            mem.mem_wdata <= storeWdata;
            funct3Q       <= funct3;
            offsetQ       <= addr[1:0];
            if (badAccess) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          counter <= counter + 8'd1;
          if (mem.mem_ack) begin
            load_data <= extLoad;
            state     <= DONE;
          end else if (counter == 8'(TIMEOUT - 1)) begin
            load_data <= 32'd0;
            bus_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: each access pushes its expected outcome,
// which is popped and compared when the access retires.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, fault, bus_err;
  logic [31:0] load_data;

  load_store_unit_if memBus();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem        (memBus),
    .stall      (stall),
    .load_data  (load_data),
    .fault      (fault),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] loadData;
    logic        checkLoad;
    logic        fault;
    logic        busErr;
    int          stallCycles;
    int          reqCycles;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memWe;
  } expect_t;

  expect_t scoreboard[$];
  int compareCount = 0;
  int errorCount   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic expect_t mkExpect(input logic [31:0] ld, input logic chk, input logic f,
                                       input logic be, input int st, input int rq,
                                       input logic [31:0] ma, input logic [3:0] mbe,
                                       input logic [31:0] wd, input logic we);
    expect_t e;
    e.loadData = ld; e.checkLoad = chk; e.fault = f; e.busErr = be;
    e.stallCycles = st; e.reqCycles = rq;
    e.memAddr = ma; e.memBe = mbe; e.memWdata = wd; e.memWe = we;
    return e;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd, input expect_t e);
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    scoreboard.push_back(e);
  endtask

  // ackDelay < 0 means the memory never answers.
  task automatic awaitResult(input string tag, input int ackDelay, input logic [31:0] rdata);
    expect_t e;
    int  stallCnt = 0;
    int  reqCnt   = 0;
    bit  done     = 1'b0;
    e = scoreboard[0];
    for (int cyc = 0; cyc < TIMEOUT + 10 && !done; cyc++) begin
      @(negedge clk);
      memBus.mem_ack = 1'b0;
      if (stall) stallCnt++;
      if (memBus.mem_req) begin
        reqCnt++;
        if (reqCnt == 1) begin
          checkOutput({tag, ".addr"}, memBus.mem_addr, e.memAddr);
          checkOutput({tag, ".be"}, {28'd0, memBus.mem_be}, {28'd0, e.memBe});
          checkOutput({tag, ".we"}, {31'd0, memBus.mem_we}, {31'd0, e.memWe});
          if (e.memWe) checkOutput({tag, ".wdata"}, memBus.mem_wdata, e.memWdata);
        end
        if (ackDelay >= 0 && reqCnt == ackDelay + 1) begin
          memBus.mem_ack   = 1'b1;
          memBus.mem_rdata = rdata;
        end
      end
      if (!stall) done = 1'b1;
    end
    if (!done) checkOutput({tag, ".retire"}, 32'd0, 32'd1);
    e = scoreboard.pop_front();
    checkOutput({tag, ".fault"}, {31'd0, fault}, {31'd0, e.fault});
    checkOutput({tag, ".busErr"}, {31'd0, bus_err}, {31'd0, e.busErr});
    checkOutput({tag, ".stallCycles"}, stallCnt, e.stallCycles);
    checkOutput({tag, ".reqCycles"}, reqCnt, e.reqCycles);
    if (e.checkLoad) checkOutput({tag, ".loadData"}, load_data, e.loadData);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0;
    memBus.mem_ack = 1'b0; memBus.mem_rdata = 32'd0;
    #3;
    checkOutput("reset.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("reset.stall", {31'd0, stall}, 32'd0);
    checkOutput("reset.we", {31'd0, memBus.mem_we}, 32'd0);
    checkOutput("reset.addr", memBus.mem_addr, 32'd0);
    checkOutput("reset.be", {28'd0, memBus.mem_be}, 32'd0);
    checkOutput("reset.wdata", memBus.mem_wdata, 32'd0);
    checkOutput("reset.loadData", load_data, 32'd0);
    checkOutput("reset.flags", {30'd0, fault, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 0, F3_W, 32'h100, 32'd0,
                  mkExpect(32'hDEADBEEF, 1, 0, 0, 2, 1, 32'h100, 4'hF, 32'd0, 0));
    awaitResult("lw", 0, 32'hDEADBEEF);

    applyStimulus(1, 0, F3_B, 32'h103, 32'd0,
                  mkExpect(32'hFFFFFF80, 1, 0, 0, 4, 3, 32'h100, 4'hF, 32'd0, 0));
    awaitResult("lb", 2, 32'h80FF0000);

    applyStimulus(1, 0, F3_BU, 32'h103, 32'd0,
                  mkExpect(32'h00000080, 1, 0, 0, 2, 1, 32'h100, 4'hF, 32'd0, 0));
    awaitResult("lbu", 0, 32'h80FF0000);

    applyStimulus(0, 1, F3_H, 32'h22, 32'h1234ABCD,
                  mkExpect(32'd0, 0, 0, 0, 3, 2, 32'h20, 4'b1100, 32'hABCDABCD, 1));
    awaitResult("sh", 1, 32'd0);

    applyStimulus(0, 1, F3_B, 32'h41, 32'h000000AB,
                  mkExpect(32'd0, 0, 0, 0, 2, 1, 32'h40, 4'b0010, 32'hABABABAB, 1));
    awaitResult("sb", 0, 32'd0);

    applyStimulus(1, 0, F3_H, 32'h102, 32'd0,
                  mkExpect(32'hFFFF8001, 1, 0, 0, 2, 1, 32'h100, 4'hF, 32'd0, 0));
    awaitResult("lh", 0, 32'h80011234);

    applyStimulus(1, 0, F3_HU, 32'h100, 32'd0,
                  mkExpect(32'h0000F00D, 1, 0, 0, 2, 1, 32'h100, 4'hF, 32'd0, 0));
    awaitResult("lhu", 0, 32'h0000F00D);

    applyStimulus(1, 0, F3_W, 32'h101, 32'd0,
                  mkExpect(32'd0, 0, 1, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0));
    awaitResult("lwMisalign", 0, 32'd0);

    applyStimulus(1, 0, F3_H, 32'h103, 32'd0,
                  mkExpect(32'd0, 0, 1, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0));
    awaitResult("lhMisalign", 0, 32'd0);

    applyStimulus(1, 0, 3'b011, 32'h100, 32'd0,
                  mkExpect(32'd0, 0, 1, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0));
    awaitResult("illegalF3", 0, 32'd0);

    applyStimulus(1, 1, F3_W, 32'h100, 32'd0,
                  mkExpect(32'd0, 0, 1, 0, 1, 0, 32'd0, 4'd0, 32'd0, 0));
    awaitResult("readWrite", 0, 32'd0);

    applyStimulus(1, 0, F3_W, 32'h180, 32'd0,
                  mkExpect(32'd0, 1, 0, 1, TIMEOUT + 1, TIMEOUT, 32'h180, 4'hF, 32'd0, 0));
    awaitResult("timeout", -1, 32'd0);

    // A straggling ack after the timeout must not disturb anything.
    repeat (2) @(negedge clk);
    memBus.mem_ack   = 1'b1;
    memBus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    memBus.mem_ack = 1'b0;
    checkOutput("lateAck.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("lateAck.stall", {31'd0, stall}, 32'd0);
    checkOutput("lateAck.busErr", {31'd0, bus_err}, 32'd0);
    checkOutput("lateAck.loadData", load_data, 32'd0);

    @(posedge clk);
    #1;
    mem_read = 1'b1; funct3 = F3_W; addr = 32'h200;
    repeat (3) @(negedge clk);
    checkOutput("midReset.reqBefore", {31'd0, memBus.mem_req}, 32'd1);
    #2;
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    checkOutput("midReset.req", {31'd0, memBus.mem_req}, 32'd0);
    checkOutput("midReset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1, F3_W, 32'h300, 32'hCAFEF00D,
                  mkExpect(32'd0, 0, 0, 0, 3, 2, 32'h300, 4'hF, 32'hCAFEF00D, 1));
    awaitResult("swAfterReset", 1, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
    $finish;
  end

endmodule
